mult_share_arbiter: RTL

- Time-shares one 32s x 26u -> 48-bit multiplier between NUM_REQ requesters in the WLAN sync datapath (correlator power, CFO scaling, AGC gain products).
- Round-robin arbitration, 2-stage registered pipeline (operand stage, product stage), single response stream tagged with requester ID.
- Sustains one product per cycle; full backpressure from the consumer.

---
 rtl/mult_share_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin shared 32s x 26u multiplier with a 2-stage pipeline (operand, product) and ID-tagged responses.
// Optional MULT_SHARE_STATS_EN adds grant and stall counters (stat_issued, stat_stall).
module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 32,
  parameter int B_W     = 26,
  parameter int P_W     = 48
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [P_W-1:0]         rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
`ifdef MULT_SHARE_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_stall
`endif
);

  typedef struct packed {
    logic [A_W-1:0]  a;
    logic [B_W-1:0]  b;
    logic [ID_W-1:0] id;
  } op_t;

  logic [NUM_REQ-1:0][A_W-1:0] a_vec;
  logic [NUM_REQ-1:0][B_W-1:0] b_vec;
  assign a_vec = req_a;
  assign b_vec = req_b;

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  op_t             s1_q, s1_d;
  logic [P_W-1:0]  s2_prod_q, s2_prod_d, prod_lo;
  logic [ID_W-1:0] s2_id_q, s2_id_d;
  logic            s1_adv, s2_adv, gnt_found, gnt;
  logic [ID_W-1:0] gnt_idx;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return ID_W'(s);
  endfunction

  assign s2_adv = !s2_vld_q || rsp_ready;
  assign s1_adv = !s1_vld_q || s2_adv;

  // Scan from the far end back toward ptr so the last hit is the nearest requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr_q, k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx(ptr_q, k);
      end
    end
  end

  assign gnt = gnt_found && s1_adv && ap_rst_n;

  always_comb begin
    req_ready = '0;
    if (gnt) req_ready[gnt_idx] = 1'b1;
  end

  // Low P_W bits only: sign-extending both operands to P_W gives the same bits as the full product.
  assign prod_lo = P_W'($signed(s1_q.a)) * P_W'($signed({1'b0, s1_q.b}));

  always_comb begin
    ptr_d     = gnt ? rr_idx(gnt_idx, 1) : ptr_q;
    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    s2_vld_d  = s2_vld_q;
    s2_prod_d = s2_prod_q;
    s2_id_d   = s2_id_q;
    if (s1_adv) begin
      s1_vld_d = gnt;
      s1_d     = '{a: a_vec[gnt_idx], b: b_vec[gnt_idx], id: gnt_idx};
    end
    if (s2_adv) begin
      s2_vld_d  = s1_vld_q;
      s2_prod_d = prod_lo;
      s2_id_d   = s1_q.id;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ptr_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s2_vld_q  <= 1'b0;
      s2_prod_q <= '0;
      s2_id_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      s2_vld_q  <= s2_vld_d;
      s2_prod_q <= s2_prod_d;
      s2_id_q   <= s2_id_d;
    end
  end

  assign rsp_valid = s2_vld_q;
  assign rsp_data  = s2_prod_q;
  assign rsp_id    = s2_id_q;
  assign busy      = s1_vld_q | s2_vld_q;

`ifdef MULT_SHARE_STATS_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  always_comb begin
    issued_d = issued_q + 32'(gnt);
    stall_d  = stall_q + 32'(s2_vld_q && !rsp_ready);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule
